game_timer_scheduler: RTL and testbench
=======================================

Name: game_timer_scheduler

Overview:
- AHB-Lite slave that shares one prescaled time base among NCH independent countdown channels.
- Channels cover game events: frame tick, ghost scatter/chase phase, frightened-mode timeout, bonus-fruit lifetime.
- Each channel is one-shot or periodic, sets a sticky expiry flag, and contributes to a single maskable interrupt for the CPU.
- Sits on the system AHB-Lite bus beside the other peripherals.

Parameters:
- NCH, 4, number of countdown channels (1..8).
- PRE_W, 16, prescaler reload width in bits.
- CNT_W, 32, channel LOAD/COUNT width in bits (max 32).

Ports:
- HCLK  input  1  system clock (50 MHz)
- HRESETn  input  1  asynchronous active-low reset
- HADDR  input  32  AHB address; only [7:0] decoded
- HWDATA  input  32  AHB write data (data phase)
- HSIZE  input  3  transfer size; ignored, all accesses treated as 32-bit
- HTRANS  input  2  transfer type; only HTRANS[1]=1 (NONSEQ/SEQ) starts an access
- HWRITE  input  1  1 = write
- HREADY  input  1  bus ready
- HSEL  input  1  slave select
- HRDATA  output  32  read data (data phase)
- HREADYOUT  output  1  always 1; zero wait states
- tick  output  1  one-cycle pulse per prescaler period
- expired  output  NCH  one-cycle pulse per channel on expiry
- irq  output  1  level: |(STATUS & IRQ_EN)

Behaviour:
- Reset: all registers 0; HRDATA=0, HREADYOUT=1, tick=0, expired=0, irq=0; prescaler counter=0.
- AHB address phase is accepted when HSEL & HREADY & HTRANS[1]; HADDR[7:2] and HWRITE are registered.
- Writes commit from HWDATA on the data-phase clock edge; the new value is visible from the next cycle.
- Reads return the register selected by the registered address, driven during the data phase.
- Unmapped or read-only targets: writes ignored; unmapped reads return 0.
- Register map (byte offsets):
  - 0x00 CTRL: [0] GEN global enable.
  - 0x04 PRESCALE: [PRE_W-1:0].
  - 0x08 STATUS: [NCH-1:0] sticky expiry flags; write-1-to-clear.
  - 0x0C IRQ_EN: [NCH-1:0] interrupt mask.
  - 0x10+0x10*n LOAD_n: reload value.
  - 0x14+0x10*n COUNT_n: read-only current count.
  - 0x18+0x10*n CFG_n: [0] EN, [1] PERIODIC.
- Prescaler:
  - GEN=0: counter held at PRESCALE value, no ticks.
  - GEN=1: counter decrements each cycle; at 0 it asserts tick for 1 cycle and reloads PRESCALE.
  - Tick period is PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE reloads the counter immediately.
- Channel start: a CFG_n write taking EN from 0 to 1 loads COUNT_n=LOAD_n in the same commit cycle.
- Channel on tick, with EN=1:
  - COUNT_n>1: decrement.
  - COUNT_n<=1: expire. Set STATUS[n] and pulse expired[n] in the cycle after the tick edge.
  - Expire with PERIODIC=1: COUNT_n=LOAD_n.
  - Expire with PERIODIC=0: COUNT_n=0 and EN is cleared by hardware.
  - LOAD_n=0 or 1 therefore expires on every tick in periodic mode.
- Channel with EN=0: COUNT_n frozen. Writing EN=0 while running stops the channel without setting STATUS.
- Writing LOAD_n while running does not alter COUNT_n; it takes effect at the next reload.
- Simultaneous events:
  - Hardware expiry set and software W1C of the same STATUS bit in one cycle: set wins.
  - CFG_n write and a tick in the same cycle: the write takes priority; no decrement that cycle.
- GEN=0: all channels freeze with counts preserved; GEN=1 resumes them.
- irq is combinational from registered STATUS/IRQ_EN. Masking a bit drops irq next cycle without clearing STATUS.
- Asynchronous reset mid-count: all state returns to reset values immediately; there is no resumption.

Test Plan:
- Reset, then read 0x00..0x4C → all 0; HREADYOUT=1 throughout; irq=0.
- PRESCALE=4, GEN=1 → tick every 5 cycles. Then write PRESCALE=9 mid-period → next tick exactly 10 cycles after the write commits.
- PRESCALE=0, LOAD_0=3, CFG_0=0b01 (one-shot) → COUNT_0 reads 3,2,1; expired[0] pulses once after 3 ticks; STATUS=0x1; CFG_0.EN reads 0; COUNT_0=0.
- PRESCALE=1, LOAD_1=2, CFG_1=0b11, IRQ_EN=0x2 → expired[1] every 4 cycles, irq=1. W1C STATUS=0x2 → irq drops. A W1C issued on an expiry cycle leaves STATUS[1]=1.
- Channel 2 running with LOAD_2=10 → write LOAD_2=5 mid-count: current period is still 10 ticks, next period 5. Then GEN=0 for 20 cycles → COUNT_2 unchanged.
- Unmapped write to 0x80 and write to COUNT_0 → no register changes; read of 0x80 → 0. Assert HRESETn=0 mid-count → COUNT, STATUS and irq are 0 immediately.

Source files
------------

// File: rtl/game_timer_scheduler.sv
// game_timer_scheduler: AHB-Lite peripheral with one shared prescaled time base
// and NCH countdown channels (one-shot or periodic). Each channel has a sticky
// expiry flag. The flags, gated by a mask, drive a single level interrupt.
module game_timer_scheduler #(
    parameter int NCH   = 4,
    parameter int PRE_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [31:0]      HADDR,
    input  logic [31:0]      HWDATA,
    input  logic [2:0]       HSIZE,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic             HREADY,
    input  logic             HSEL,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             tick,
    output logic [NCH-1:0]   expired,
    output logic             irq
);

    // Bus pipeline state for the current data phase.
    logic             wr_q;
    logic             rd_q;
    logic [5:0]       idx_q;

    // Global registers and the prescaler.
    logic             gen;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick_q;
    logic [NCH-1:0]   status;
    logic [NCH-1:0]   irq_en;

    // Per-channel state.
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   periodic;
    logic [NCH-1:0]   expired_q;
    logic [CNT_W-1:0] load_val  [NCH];
    logic [CNT_W-1:0] count_val [NCH];

    // Decoded write strobes and per-cycle events.
    logic             wr_ctrl;
    logic             wr_pre;
    logic             wr_status;
    logic             wr_irq_en;
    logic [NCH-1:0]   wr_load;
    logic [NCH-1:0]   wr_cfg;
    logic [NCH-1:0]   expire_now;
    logic             step;

    // Inputs the register map never looks at.
    logic             unused_bits;
    assign unused_bits = ^{HSIZE, HTRANS[0], HADDR[31:8], HADDR[1:0]};

    // Register the address phase of each accepted transfer.
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            idx_q <= '0;
        end else if (HREADY) begin
            wr_q  <= HSEL & HTRANS[1] & HWRITE;
            rd_q  <= HSEL & HTRANS[1] & ~HWRITE;
            idx_q <= HADDR[7:2];
        end
    end

    assign wr_ctrl   = wr_q & HREADY & (idx_q == 6'd0);
    assign wr_pre    = wr_q & HREADY & (idx_q == 6'd1);
    assign wr_status = wr_q & HREADY & (idx_q == 6'd2);
    assign wr_irq_en = wr_q & HREADY & (idx_q == 6'd3);

    // Decode the per-channel LOAD and CFG write strobes. Channel n occupies word block n+1.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_load = '0;
        wr_cfg  = '0;
        for (int n = 0; n < NCH; n++) begin
            if (wr_q && HREADY && idx_q[5:2] == 4'(n + 1)) begin
                wr_load[n] = (idx_q[1:0] == 2'd0);
                wr_cfg[n]  = (idx_q[1:0] == 2'd2);
            end
        end
    end

    assign step = tick_q & gen;

    // Work out which channels expire on this edge. A CFG write in the same cycle takes priority.
    always_comb begin
        expire_now = '0;
        for (int n = 0; n < NCH; n++) begin
            expire_now[n] = step && en[n] && !wr_cfg[n] && (count_val[n] <= CNT_W'(1));
        end
    end

    // Global registers. When a hardware expiry and a W1C hit the same STATUS bit, the expiry wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gen      <= 1'b0;
            prescale <= '0;
            irq_en   <= '0;
            status   <= '0;
        end else begin
            if (wr_ctrl)   gen      <= HWDATA[0];
            if (wr_pre)    prescale <= HWDATA[PRE_W-1:0];
            if (wr_irq_en) irq_en   <= HWDATA[NCH-1:0];
            status <= (status & ~(wr_status ? HWDATA[NCH-1:0] : {NCH{1'b0}})) | expire_now;
        end
    end

    // Prescaler. It is held at PRESCALE while disabled and restarts on any PRESCALE write.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= gen && !wr_pre && (pre_cnt == '0);
            if (wr_pre)
                pre_cnt <= HWDATA[PRE_W-1:0];
            else if (!gen || pre_cnt == '0)
                pre_cnt <= prescale;
            else
                pre_cnt <= pre_cnt - PRE_W'(1);
        end
    end

    // Channel counters. Starting a channel loads COUNT. A tick decrements COUNT or expires the channel.
    // NOTE: the LOAD/COUNT arrays are software-visible registers, so they are reset too.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int n = 0; n < NCH; n++) begin
                load_val[n]  <= '0;
                count_val[n] <= '0;
            end
            en        <= '0;
            periodic  <= '0;
            expired_q <= '0;
        end else begin
            expired_q <= expire_now;
            for (int n = 0; n < NCH; n++) begin
                if (wr_load[n]) load_val[n] <= HWDATA[CNT_W-1:0];
                if (wr_cfg[n]) begin
                    en[n]       <= HWDATA[0];
                    periodic[n] <= HWDATA[1];
                    if (HWDATA[0] && !en[n]) count_val[n] <= load_val[n];
                end else if (expire_now[n]) begin
                    if (periodic[n]) begin
                        count_val[n] <= load_val[n];
                    end else begin
                        count_val[n] <= '0;
                        en[n]        <= 1'b0;
                    end
                end else if (step && en[n]) begin
                    count_val[n] <= count_val[n] - CNT_W'(1);
                end
            end
        end
    end

    // Read mux. It selects from the registered address and returns 0 for unmapped words.
    always_comb begin
        HRDATA = '0;
        if (rd_q) begin
            case (idx_q)
                6'd0:    HRDATA[0]         = gen;
                6'd1:    HRDATA[PRE_W-1:0] = prescale;
                6'd2:    HRDATA[NCH-1:0]   = status;
                6'd3:    HRDATA[NCH-1:0]   = irq_en;
                default: ;
            endcase
            for (int n = 0; n < NCH; n++) begin
                if (idx_q[5:2] == 4'(n + 1)) begin
                    case (idx_q[1:0])
                        2'd0:    HRDATA[CNT_W-1:0] = load_val[n];
                        2'd1:    HRDATA[CNT_W-1:0] = count_val[n];
                        2'd2:    HRDATA[1:0]       = {periodic[n], en[n]};
                        default: ;
                    endcase
                end
            end
        end
    end

    assign HREADYOUT = 1'b1;
    assign tick      = tick_q;
    assign expired   = expired_q;
    assign irq       = |(status & irq_en);

endmodule

// File: tb/tb_game_timer_scheduler.sv
// Directed testbench for game_timer_scheduler. Each scenario task drives its
// own bus traffic and compares the outputs against hand-computed values.
module tb_game_timer_scheduler;

    localparam int NCH = 4;

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic [31:0]    HADDR;
    logic [31:0]    HWDATA;
    logic [2:0]     HSIZE;
    logic [1:0]     HTRANS;
    logic           HWRITE;
    logic           HREADY;
    logic           HSEL;
    logic [31:0]    HRDATA;
    logic           HREADYOUT;
    logic           tick;
    logic [NCH-1:0] expired;
    logic           irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd;

    game_timer_scheduler #(.NCH(NCH), .PRE_W(16), .CNT_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
        .HSEL(HSEL), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .tick(tick),
        .expired(expired), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = '0;
    endtask

    // Address phase now, data phase next cycle. Returns 1 ns after the commit edge.
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    // The data is sampled mid data phase.
    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        bus_idle();
        data = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({HRDATA, HREADYOUT, tick, expired, irq} !== {32'h0, 1'b1, 1'b0, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdata=%h ready=%b tick=%b exp=%b irq=%b, want 0/1/0/0/0",
                     HRDATA, HREADYOUT, tick, expired, irq);
        end
        for (int a = 0; a <= 32'h4C; a += 4) begin
            ahb_read(32'(a), rd);
            n_cmp++;
            if (rd !== 32'h0 || HREADYOUT !== 1'b1 || irq !== 1'b0) begin
                n_err++;
                $display("FAIL reset_read_%0h: got data=%h ready=%b irq=%b, want 0/1/0", a, rd, HREADYOUT, irq);
            end
        end
    endtask

    task automatic test_prescaler();
        ahb_write(32'h04, 32'd4);
        ahb_write(32'h00, 32'd1);
        for (int k = 1; k <= 15; k++) begin
            @(posedge HCLK); #1;
            n_cmp++;
            if (tick !== (k % 5 == 0)) begin
                n_err++;
                $display("FAIL tick_pre4_k%0d: got %b, want %b", k, tick, (k % 5 == 0));
            end
        end
        ahb_write(32'h04, 32'd9);
        for (int k = 1; k <= 11; k++) begin
            @(posedge HCLK); #1;
            n_cmp++;
            if (tick !== (k == 10)) begin
                n_err++;
                $display("FAIL tick_pre9_k%0d: got %b, want %b", k, tick, (k == 10));
            end
        end
    endtask

    task automatic test_oneshot();
        int exp_cnt[4] = '{3, 2, 1, 0};
        ahb_write(32'h04, 32'd0);
        ahb_write(32'h10, 32'd3);
        // The CFG_0 write data phase overlaps a streaming read of COUNT_0.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h18;
        @(posedge HCLK); #1;
        HWDATA = 32'h1; HWRITE = 1'b0; HADDR = 32'h14;
        @(posedge HCLK); #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (HRDATA !== 32'(exp_cnt[k]) || expired[0] !== (k == 3)) begin
                n_err++;
                $display("FAIL oneshot_k%0d: got count=%0d exp0=%b, want count=%0d exp0=%b",
                         k, HRDATA, expired[0], exp_cnt[k], (k == 3));
            end
            if (k < 3) begin
                @(posedge HCLK); #1;
            end
        end
        bus_idle();
        @(posedge HCLK); #1;
        n_cmp++;
        if (expired !== 4'h0) begin
            n_err++;
            $display("FAIL oneshot_single_pulse: got expired=%b, want 0000", expired);
        end
        ahb_read(32'h08, rd);
        n_cmp++;
        if (rd !== 32'h1) begin n_err++; $display("FAIL oneshot_status: got %h, want 1", rd); end
        ahb_read(32'h18, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL oneshot_cfg_en: got %h, want 0", rd); end
        ahb_read(32'h14, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL oneshot_count: got %h, want 0", rd); end
        ahb_write(32'h08, 32'h1);
        ahb_read(32'h08, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL w1c_status0: got %h, want 0", rd); end
    endtask

    task automatic test_periodic_irq();
        bit found = 1'b0;
        ahb_write(32'h04, 32'd1);
        ahb_write(32'h20, 32'd2);
        ahb_write(32'h0C, 32'h2);
        ahb_write(32'h28, 32'h3);
        for (int i = 0; i < 20; i++) begin
            @(posedge HCLK); #1;
            if (expired[1]) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL periodic_first: got no expiry in 20 cycles, want one"); end
        for (int k = 1; k <= 8; k++) begin
            @(posedge HCLK); #1;
            n_cmp++;
            if (expired[1] !== (k % 4 == 0)) begin
                n_err++;
                $display("FAIL periodic_k%0d: got %b, want %b", k, expired[1], (k % 4 == 0));
            end
        end
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b, want 1", irq); end
        // This W1C commits two cycles after an expiry, so it does not collide with one.
        ahb_write(32'h08, 32'h2);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c: got %b, want 0", irq); end
        ahb_read(32'h08, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL status_w1c: got %h, want 0", rd); end
        // Time is now 1 ns after an expiry edge. This W1C commits exactly on the following expiry edge.
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        ahb_write(32'h08, 32'h2);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b, want 1", irq); end
        ahb_read(32'h08, rd);
        n_cmp++;
        if (rd !== 32'h2) begin n_err++; $display("FAIL status_set_wins: got %h, want 2", rd); end
        ahb_write(32'h0C, 32'h0);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b, want 0", irq); end
        ahb_read(32'h08, rd);
        n_cmp++;
        if (rd !== 32'h2) begin n_err++; $display("FAIL status_kept_masked: got %h, want 2", rd); end
        ahb_write(32'h28, 32'h0);
        ahb_write(32'h08, 32'h2);
        ahb_read(32'h08, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL stop_no_status: got %h, want 0", rd); end
    endtask

    task automatic test_load_update_and_freeze();
        bit found = 1'b0;
        ahb_write(32'h04, 32'd0);
        ahb_write(32'h30, 32'd10);
        ahb_write(32'h38, 32'h3);
        ahb_write(32'h30, 32'd5);
        for (int k = 3; k <= 16; k++) begin
            @(posedge HCLK); #1;
            n_cmp++;
            if (expired[2] !== (k == 10 || k == 15)) begin
                n_err++;
                $display("FAIL load_update_k%0d: got %b, want %b", k, expired[2], (k == 10 || k == 15));
            end
        end
        ahb_write(32'h00, 32'd0);
        ahb_read(32'h34, rd);
        n_cmp++;
        if (rd !== 32'd2) begin n_err++; $display("FAIL freeze_count_a: got %0d, want 2", rd); end
        repeat (20) @(posedge HCLK);
        #1;
        ahb_read(32'h34, rd);
        n_cmp++;
        if (rd !== 32'd2) begin n_err++; $display("FAIL freeze_count_b: got %0d, want 2", rd); end
        ahb_write(32'h00, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge HCLK); #1;
            if (expired[2]) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL resume: got no expiry in 10 cycles, want one"); end
    endtask

    task automatic test_unmapped_and_reset();
        logic [31:0] addrs [6] = '{32'h80, 32'h14, 32'h10, 32'h04, 32'h00, 32'h08};
        logic [31:0] wants [6] = '{32'h0,  32'h0,  32'h3,  32'h0,  32'h1,  32'h4};
        ahb_write(32'h80, 32'hFFFF_FFFF);
        ahb_write(32'h14, 32'h55);
        for (int i = 0; i < 6; i++) begin
            ahb_read(addrs[i], rd);
            n_cmp++;
            if (rd !== wants[i]) begin
                n_err++;
                $display("FAIL unmapped_read_%0h: got %h, want %h", addrs[i], rd, wants[i]);
            end
        end
        ahb_write(32'h0C, 32'h4);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_pre_reset: got %b, want 1", irq); end
        HRESETn = 1'b0;
        #2;
        n_cmp++;
        if ({irq, tick, expired, HRDATA} !== {1'b0, 1'b0, 4'h0, 32'h0}) begin
            n_err++;
            $display("FAIL async_reset: got irq=%b tick=%b exp=%b rdata=%h, want all 0", irq, tick, expired, HRDATA);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(32'h34, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL reset_count2: got %h, want 0", rd); end
        ahb_read(32'h08, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h, want 0", rd); end
        ahb_read(32'h38, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL reset_cfg2: got %h, want 0", rd); end
    endtask

    initial begin
        HRESETn = 1'b0;
        HWDATA  = '0;
        HSIZE   = 3'b010;
        HREADY  = 1'b1;
        bus_idle();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        test_reset();
        test_prescaler();
        test_oneshot();
        test_periodic_irq();
        test_load_update_and_freeze();
        test_unmapped_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
